// File: rtl/sonic_v1_15_eth_10g_mac_tx_stat_counters_pkg.sv
// Shared definitions for the 10G MAC TX statistics collector: CSR map,
// status-word field positions, error bit indices and frame-size histogram bins.
package sonic_v1_15_eth_10g_mac_tx_stat_counters_pkg;

  localparam int LEN_W     = 16;
  localparam int BIT_UCAST = 16;
  localparam int BIT_PAUSE = 19;
  localparam int ERR_W     = 7;

  localparam int ERR_UNDERSIZE   = 0;
  localparam int ERR_OVERSIZE    = 1;
  localparam int ERR_PAYLOAD_LEN = 2;
  localparam int ERR_CRC         = 3;
  localparam int ERR_UNDERFLOW   = 4;
  localparam int ERR_USER        = 5;

  // Counter slots, ordered to match the CSR map starting at ADDR_FRAMES_OK
  localparam int CNT_FRAMES_OK   = 0;
  localparam int CNT_FRAMES_ERR  = 1;
  localparam int CNT_CRC         = 2;
  localparam int CNT_UNDERSIZE   = 3;
  localparam int CNT_OVERSIZE    = 4;
  localparam int CNT_PAYLOAD_LEN = 5;
  localparam int CNT_UNDERFLOW   = 6;
  localparam int CNT_USER        = 7;
  localparam int CNT_UNICAST     = 8;
  localparam int CNT_MULTICAST   = 9;
  localparam int CNT_BROADCAST   = 10;
  localparam int CNT_PAUSE       = 11;
  localparam int NUM_CNT         = 12;

  typedef logic [4:0] csr_addr_t;

  localparam csr_addr_t ADDR_CTRL      = 5'h00;
  localparam csr_addr_t ADDR_FRAMES_OK = 5'h01;
  localparam csr_addr_t ADDR_OCT_LO    = 5'h0D;
  localparam csr_addr_t ADDR_OCT_HI    = 5'h0E;
  localparam csr_addr_t ADDR_HIST_BASE = 5'h10;

  localparam int HIST_BINS = 8;

  localparam logic [LEN_W-1:0] HIST_LIM_64    = 16'd64;
  localparam logic [LEN_W-1:0] HIST_LIM_127   = 16'd127;
  localparam logic [LEN_W-1:0] HIST_LIM_255   = 16'd255;
  localparam logic [LEN_W-1:0] HIST_LIM_511   = 16'd511;
  localparam logic [LEN_W-1:0] HIST_LIM_1023  = 16'd1023;
  localparam logic [LEN_W-1:0] HIST_LIM_1518  = 16'd1518;

  // Class bits are kept in in_data order: [0] unicast .. [3] pause
  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
    logic [3:0]       cls;
    logic [ERR_W-1:0] err;
  } beat_t;

  function automatic logic [2:0] hist_bin(input logic [LEN_W-1:0] len);
    if (len < HIST_LIM_64)        return 3'd0;
    else if (len == HIST_LIM_64)  return 3'd1;
    else if (len <= HIST_LIM_127) return 3'd2;
    else if (len <= HIST_LIM_255) return 3'd3;
    else if (len <= HIST_LIM_511) return 3'd4;
    else if (len <= HIST_LIM_1023) return 3'd5;
    else if (len <= HIST_LIM_1518) return 3'd6;
    else                           return 3'd7;
  endfunction

endpackage

// File: rtl/sonic_v1_15_eth_10g_mac_tx_stat_counters_stat_cnt.sv
// Saturating accumulator with synchronous clear. Clear zeroes the old value
// first, then the same-cycle increment is applied on top of zero.
module sonic_v1_15_eth_10g_stat_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc_en,
  input  logic [W-1:0] inc_val,
  output logic [W-1:0] cnt
);

  logic [W-1:0] base;
  logic [W:0]   sum;
  logic [W-1:0] cnt_nxt;

  always_comb begin
    base    = clr ? '0 : cnt;
    sum     = {1'b0, base} + {1'b0, inc_val};
    cnt_nxt = base;
    if (inc_en) begin
      cnt_nxt = sum[W] ? '1 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/sonic_v1_15_eth_10g_mac_tx_stat_counters.sv
// TX statistics collector: per-frame status beats into saturating counters, read over
// an Avalon-MM CSR slave. Define SONIC_TX_STAT_HIST_EN to add the frame-size histogram.
module sonic_v1_15_eth_10g_mac_tx_stat_counters
  import sonic_v1_15_eth_10g_mac_tx_stat_counters_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int OCT_W = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [39:0] in_data,
  input  logic [6:0]  in_error,
  input  logic [4:0]  csr_address,
  input  logic        csr_read,
  input  logic        csr_write,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata
);

  beat_t              s1;
  logic               clr;
  logic               good;
  logic               bad;
  logic [NUM_CNT-1:0] inc;
  logic [CNT_W-1:0]   cnt [NUM_CNT];
  logic [OCT_W-1:0]   oct;
  logic [OCT_W-33:0]  oct_shadow;
  logic [31:0]        rd_mux;
  logic               unused_in;

  assign unused_in = ^{in_data[39:20], csr_writedata[31:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
    end else begin
      s1.valid <= in_valid;
      s1.len   <= in_data[LEN_W-1:0];
      s1.cls   <= in_data[BIT_PAUSE:BIT_UCAST];
      s1.err   <= in_error;
    end
  end

  assign clr  = csr_write && (csr_address == ADDR_CTRL) && csr_writedata[0];
  assign good = s1.valid && (s1.err == '0);
  assign bad  = s1.valid && (s1.err != '0);

  always_comb begin
    inc                  = '0;
    inc[CNT_FRAMES_OK]   = good;
    inc[CNT_FRAMES_ERR]  = bad;
    inc[CNT_CRC]         = bad && s1.err[ERR_CRC];
    inc[CNT_UNDERSIZE]   = bad && s1.err[ERR_UNDERSIZE];
    inc[CNT_OVERSIZE]    = bad && s1.err[ERR_OVERSIZE];
    inc[CNT_PAYLOAD_LEN] = bad && s1.err[ERR_PAYLOAD_LEN];
    inc[CNT_UNDERFLOW]   = bad && s1.err[ERR_UNDERFLOW];
    inc[CNT_USER]        = bad && s1.err[ERR_USER];
    inc[CNT_UNICAST]     = good && s1.cls[0];
    inc[CNT_MULTICAST]   = good && s1.cls[1];
    inc[CNT_BROADCAST]   = good && s1.cls[2];
    inc[CNT_PAUSE]       = good && s1.cls[3];
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    sonic_v1_15_eth_10g_stat_cnt #(.W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc_en  (inc[i]),
      .inc_val (CNT_W'(1)),
      .cnt     (cnt[i])
    );
  end

  sonic_v1_15_eth_10g_stat_cnt #(.W(OCT_W)) u_oct (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc_en  (good),
    .inc_val (OCT_W'(s1.len)),
    .cnt     (oct)
  );

`ifdef SONIC_TX_STAT_HIST_EN
  logic [CNT_W-1:0] hist [HIST_BINS];
  logic [2:0]       s1_bin;

  assign s1_bin = hist_bin(s1.len);

  for (genvar b = 0; b < HIST_BINS; b++) begin : g_hist
    sonic_v1_15_eth_10g_stat_cnt #(.W(CNT_W)) u_bin (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .inc_en  (good && (s1_bin == 3'(b))),
      .inc_val (CNT_W'(1)),
      .cnt     (hist[b])
    );
  end
`endif

  // Lo read snapshots the live high word so a following hi read is coherent
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oct_shadow <= '0;
    end else if (clr) begin
      oct_shadow <= '0;
    end else if (csr_read && (csr_address == ADDR_OCT_LO)) begin
      oct_shadow <= oct[OCT_W-1:32];
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (csr_address == 5'(int'(ADDR_FRAMES_OK) + i)) begin
        rd_mux = 32'(cnt[i]);
      end
    end
    if (csr_address == ADDR_OCT_LO) begin
      rd_mux = oct[31:0];
    end
    if (csr_address == ADDR_OCT_HI) begin
      rd_mux = 32'(oct_shadow);
    end
`ifdef SONIC_TX_STAT_HIST_EN
    for (int b = 0; b < HIST_BINS; b++) begin
      if (csr_address == 5'(int'(ADDR_HIST_BASE) + b)) begin
        rd_mux = 32'(hist[b]);
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sonic_v1_15_eth_10g_mac_tx_stat_counters.sv
// Bench for the TX statistics collector: a full-width instance and a narrow
// instance (CNT_W=4, OCT_W=33) share stimulus and are checked against a frame-level model.
module tb_sonic_v1_15_eth_10g_mac_tx_stat_counters;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [39:0] in_data;
  logic [6:0]  in_error;
  logic [4:0]  csr_address;
  logic        csr_read;
  logic        csr_write;
  logic [31:0] csr_writedata;
  logic [31:0] rdata_m;
  logic [31:0] rdata_s;

  int passed = 0;
  int total  = 0;

  logic [63:0] m_cnt  [2][12];
  logic [63:0] m_hist [2][8];
  logic [63:0] m_oct  [2];
  logic [31:0] m_sh   [2];

  sonic_v1_15_eth_10g_mac_tx_stat_counters #(.CNT_W(32), .OCT_W(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(rdata_m));

  sonic_v1_15_eth_10g_mac_tx_stat_counters #(.CNT_W(4), .OCT_W(33)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(rdata_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] cmax(input int k);
    return (k == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic logic [64:0] omax(input int k);
    return (k == 0) ? {1'b0, {64{1'b1}}} : (65'd1 << 33) - 65'd1;
  endfunction

  function automatic int size_bin(input int len);
    int lim [7] = '{63, 64, 127, 255, 511, 1023, 1518};
    for (int i = 0; i < 7; i++) if (len <= lim[i]) return i;
    return 7;
  endfunction

  task automatic m_inc(input int k, input int idx);
    if (m_cnt[k][idx] < cmax(k)) m_cnt[k][idx] = m_cnt[k][idx] + 1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 12; i++) m_cnt[k][i] = 0;
      for (int i = 0; i < 8; i++) m_hist[k][i] = 0;
      m_oct[k] = 0;
      m_sh[k]  = 0;
    end
  endtask

  task automatic model_beat(input int len, input logic [3:0] cls, input logic [6:0] err);
    logic [64:0] s;
    int b;
    // error bit -> counter slot (undersize, oversize, payload_length, crc, underflow, user)
    int emap [6] = '{3, 4, 5, 2, 6, 7};
    for (int k = 0; k < 2; k++) begin
      if (err == 0) begin
        m_inc(k, 0);
        s = {1'b0, m_oct[k]} + 65'(len);
        if (s > omax(k)) s = omax(k);
        m_oct[k] = s[63:0];
        for (int c = 0; c < 4; c++) if (cls[c]) m_inc(k, 8 + c);
        b = size_bin(len);
        if (m_hist[k][b] < cmax(k)) m_hist[k][b] = m_hist[k][b] + 1;
      end else begin
        m_inc(k, 1);
        for (int e = 0; e < 6; e++) if (err[e]) m_inc(k, emap[e]);
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input int k, input logic [4:0] a);
    if (a >= 5'h01 && a <= 5'h0C) return m_cnt[k][int'(a) - 1][31:0];
    if (a == 5'h0D) return m_oct[k][31:0];
    if (a == 5'h0E) return m_sh[k];
`ifdef SONIC_TX_STAT_HIST_EN
    if (a >= 5'h10 && a <= 5'h17) return m_hist[k][int'(a) - 16][31:0];
`endif
    return 32'h0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    step();
    step();
  endtask

  task automatic beat_raw(input logic [15:0] len, input logic [3:0] cls, input logic [6:0] err);
    logic [31:0] r;
    r        = $urandom();
    in_valid = 1'b1;
    in_data  = {r[19:0], cls, len};
    in_error = err;
    step();
    r        = $urandom();
    in_valid = 1'b0;
    in_data  = {r[7:0], r};
    in_error = r[6:0];
  endtask

  task automatic beat(input logic [15:0] len, input logic [3:0] cls, input logic [6:0] err);
    beat_raw(len, cls, err);
    model_beat(int'(len), cls, err);
  endtask

  task automatic rd(input logic [4:0] a, input string tag, output logic [31:0] v);
    logic [31:0] e0, e1;
    e0 = exp_rd(0, a);
    e1 = exp_rd(1, a);
    csr_address = a;
    csr_read    = 1'b1;
    step();
    csr_read = 1'b0;
    if (a == 5'h0D) begin
      m_sh[0] = 32'(m_oct[0] >> 32);
      m_sh[1] = 32'(m_oct[1] >> 32);
    end
    chk($sformatf("%s@%0h main", tag, a), 64'(rdata_m), 64'(e0));
    chk($sformatf("%s@%0h narrow", tag, a), 64'(rdata_s), 64'(e1));
    v = rdata_m;
  endtask

  task automatic rd_all(input string tag);
    logic [31:0] v;
    for (int a = 0; a < 32; a++) rd(5'(a), tag, v);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    step();
    csr_write = 1'b0;
    if (a == 5'h00 && d[0]) model_clear();
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] hold_m, hold_s;
    logic [15:0] len;
    logic [6:0]  err;
    logic [31:0] r;

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; in_error = '0;
    csr_address = 5'h01; csr_read = 1'b1; csr_write = 1'b0; csr_writedata = '0;
    model_clear();
    step(); step(); step();
    chk("readdata_in_reset main", 64'(rdata_m), 64'h0);
    chk("readdata_in_reset narrow", 64'(rdata_s), 64'h0);
    csr_read = 1'b0;
    reset = 1'b0;
    step();
    rd_all("after_reset");

    beat(16'd64, 4'b0001, 7'd0);
    beat(16'd1500, 4'b0001, 7'd0);
    beat(16'd9000, 4'b0001, 7'd0);
    drain();
    rd(5'h01, "frames_ok", v);     chk("frames_ok_is_3", 64'(v), 64'd3);
    rd(5'h09, "unicast", v);       chk("unicast_is_3", 64'(v), 64'd3);
    rd(5'h0D, "oct_lo", v);        chk("oct_lo_is_10564", 64'(v), 64'd10564);
    rd(5'h0E, "oct_hi", v);        chk("oct_hi_is_0", 64'(v), 64'd0);
    rd(5'h02, "frames_err", v);    chk("frames_err_is_0", 64'(v), 64'd0);

    beat(16'd100, 4'b0001, 7'b0001001);
    drain();
    rd(5'h02, "err_frames_err", v); chk("frames_err_is_1", 64'(v), 64'd1);
    rd(5'h04, "err_undersize", v);  chk("undersize_is_1", 64'(v), 64'd1);
    rd(5'h03, "err_crc", v);        chk("crc_is_1", 64'(v), 64'd1);
    rd(5'h0D, "err_oct_lo", v);     chk("oct_lo_unchanged", 64'(v), 64'd10564);
    rd(5'h01, "err_frames_ok", v);  chk("frames_ok_unchanged", 64'(v), 64'd3);

    // Randomised traffic; the narrow instance saturates along the way
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 3))
        0:       len = 16'($urandom_range(0, 80));
        1:       len = 16'($urandom_range(60, 1600));
        2:       len = 16'($urandom_range(1500, 9600));
        default: len = 16'(65535 - $urandom_range(0, 3));
      endcase
      err = ($urandom_range(0, 1) == 1) ? 7'd0 : 7'($urandom_range(1, 127));
      r = $urandom();
      beat(len, r[3:0], err);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    rd_all("random");

    wr(5'h00, 32'h0000_0002);
    wr(5'h05, 32'hFFFF_FFFF);
    drain();
    rd_all("no_clear_writes");

    csr_address = 5'h00; csr_writedata = 32'h1; csr_write = 1'b1; csr_read = 1'b1;
    step();
    csr_write = 1'b0; csr_read = 1'b0;
    chk("rdwr_ctrl_reads_0 main", 64'(rdata_m), 64'h0);
    model_clear();
    rd_all("after_clear");

    beat(16'd300, 4'b0110, 7'd0);
    beat(16'd70, 4'b1000, 7'b0100000);
    beat_raw(16'd64, 4'b0001, 7'd0);
    wr(5'h00, 32'h0000_0001);
    model_beat(64, 4'b0001, 7'd0);
    drain();
    rd(5'h01, "clr_evt_frames_ok", v); chk("clr_evt_frames_ok_is_1", 64'(v), 64'd1);
    rd(5'h0D, "clr_evt_oct_lo", v);    chk("clr_evt_oct_lo_is_64", 64'(v), 64'd64);
    rd_all("clear_event_collision");

    rd(5'h01, "hold_pre", v);
    hold_m = rdata_m; hold_s = rdata_s;
    beat(16'd128, 4'b0001, 7'd0);
    drain(); step();
    chk("readdata_holds main", 64'(rdata_m), 64'(hold_m));
    chk("readdata_holds narrow", 64'(rdata_s), 64'(hold_s));

    beat_raw(16'd500, 4'b0001, 7'd0);
    beat_raw(16'd700, 4'b0011, 7'd0);
    #2 reset = 1'b1;
    step();
    reset = 1'b0;
    model_clear();
    drain();
    rd(5'h01, "midreset", v);
    rd(5'h0A, "midreset", v);
    rd(5'h0D, "midreset", v);

    // 65537 x 65535 = 2^32 - 1, one short of carrying into the high word
    for (int n = 0; n < 65537; n++) beat(16'hFFFF, 4'b0000, 7'd0);
    drain();
    rd(5'h0D, "bnd_lo", v);  chk("bnd_lo_all_ones", 64'(v), 64'hFFFF_FFFF);
    beat(16'hFFFF, 4'b0000, 7'd0);
    drain();
    rd(5'h0E, "bnd_hi_shadow", v); chk("bnd_hi_latched_0", 64'(v), 64'd0);
    rd(5'h0D, "bnd_lo2", v);       chk("bnd_lo_after_carry", 64'(v), 64'd65534);
    rd(5'h0E, "bnd_hi2", v);       chk("bnd_hi_relatched_1", 64'(v), 64'd1);
    rd(5'h01, "bnd_frames_ok", v); chk("bnd_frames_ok", 64'(v), 64'd65538);
    wr(5'h00, 32'h0000_0001);
    rd(5'h0E, "shadow_cleared", v);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
